// File: rtl/bscan_tap_pkg.sv
// ============================================================================
// bscan_tap_pkg : TAP state encoding and default opcodes for bscan_tap_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package bscan_tap_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'h0,
    TAP_EX1_DR = 4'h1,
    TAP_SH_DR  = 4'h2,
    TAP_PA_DR  = 4'h3,
    TAP_SEL_IR = 4'h4,
    TAP_UPD_DR = 4'h5,
    TAP_CAP_DR = 4'h6,
    TAP_SEL_DR = 4'h7,
    TAP_EX2_IR = 4'h8,
    TAP_EX1_IR = 4'h9,
    TAP_SH_IR  = 4'hA,
    TAP_PA_IR  = 4'hB,
    TAP_RTI    = 4'hC,
    TAP_UPD_IR = 4'hD,
    TAP_CAP_IR = 4'hE,
    TAP_TLR    = 4'hF
  } tap_state_t;

  localparam int C_OP_EXTEST = 0;
  localparam int C_OP_SAMPLE = 1;
  localparam int C_OP_INTEST = 2;
  localparam int C_OP_IDCODE = 3;

  // BYPASS is all-ones for whatever IR width is in use
  function automatic logic [7:0] bypass_opcode(input int ir_w);
    return 8'((1 << ir_w) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bscan_tap_fsm.sv
// ============================================================================
// bscan_tap_fsm : 16-state IEEE 1149.1 TAP state register and next-state logic
// Rev 1.0
// ============================================================================
`default_nettype none

module bscan_tap_fsm
  import bscan_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms_i,
  output logic [3:0] state_o,
  output logic [3:0] state_next_o
);

  tap_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TAP_TLR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_TLR:    state_d = tms_i ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: state_d = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: state_d = tms_i ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  state_d = tms_i ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: state_d = tms_i ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: state_d = tms_i ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: state_d = tms_i ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  state_d = tms_i ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: state_d = tms_i ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
    endcase
  end

  always_comb begin
    state_o      = state_q;
    state_next_o = state_d;
  end

endmodule

`default_nettype wire

// File: rtl/bscan_tap_ctrl.sv
// ============================================================================
// bscan_tap_ctrl : TAP controller with IR, BYPASS and boundary-cell decode
// Optional 32-bit IDCODE register enabled by defining BSCAN_TAP_IDCODE_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module bscan_tap_ctrl
  import bscan_tap_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          OP_EXTEST  = C_OP_EXTEST,
  parameter int          OP_SAMPLE  = C_OP_SAMPLE,
  parameter int          OP_INTEST  = C_OP_INTEST,
  parameter int          OP_IDCODE  = C_OP_IDCODE,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tms,
  input  logic            tdi,
  input  logic            bsr_so,
  output logic            tdo,
  output logic            tdo_en,
  output logic            bc_capture_en,
  output logic            bc_update_en,
  output logic            bc_shift_dr,
  output logic            bc_mode,
  output logic            bc_intest,
  output logic            bc_si,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] instr
);

  localparam logic [IR_W-1:0] c_extest = IR_W'(OP_EXTEST);
  localparam logic [IR_W-1:0] c_sample = IR_W'(OP_SAMPLE);
  localparam logic [IR_W-1:0] c_intest = IR_W'(OP_INTEST);
  localparam logic [IR_W-1:0] c_bypass = IR_W'(bypass_opcode(IR_W));
  localparam logic [IR_W-1:0] c_ir_cap = IR_W'(1);

  logic [3:0]      state, state_nxt;
  tap_state_t      st;
  logic [IR_W-1:0] ir_sr_q, instr_q;
  logic            byp_q;
  logic            is_bsr, is_id, id_so, dr_so;

  bscan_tap_fsm u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .tms_i        (tms),
    .state_o      (state),
    .state_next_o (state_nxt)
  );

  assign st = tap_state_t'(state);

`ifdef BSCAN_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] c_idcode    = IR_W'(OP_IDCODE);
  localparam logic [IR_W-1:0] c_rst_instr = c_idcode;
  localparam logic [31:0]     c_id_val    = IDCODE_VAL | 32'h1;

  logic [31:0] id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                id_q <= c_id_val;
    else if (st == TAP_CAP_DR) id_q <= c_id_val;
    else if (st == TAP_SH_DR)  id_q <= {tdi, id_q[31:1]};
  end

  assign id_so = id_q[0];
  assign is_id = (instr_q == c_idcode) && !is_bsr;
`else
  localparam logic [IR_W-1:0] c_rst_instr = c_bypass;

  logic unused_cfg;
  assign unused_cfg = ^{IDCODE_VAL, 32'(OP_IDCODE)};
  assign id_so      = 1'b0;
  assign is_id      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_sr_q <= '0;
      byp_q   <= 1'b0;
      instr_q <= c_rst_instr;
    end else begin
      case (st)
        TAP_CAP_IR: ir_sr_q <= c_ir_cap;
        TAP_SH_IR:  ir_sr_q <= {tdi, ir_sr_q[IR_W-1:1]};
        TAP_CAP_DR: byp_q   <= 1'b0;
        TAP_SH_DR:  byp_q   <= tdi;
        default: ;
      endcase
      // Looking at the next state makes instr valid for the whole TLR stay
      if (state_nxt == TAP_TLR)  instr_q <= c_rst_instr;
      else if (st == TAP_UPD_IR) instr_q <= ir_sr_q;
    end
  end

  always_comb begin
    is_bsr = (instr_q == c_extest) || (instr_q == c_sample) || (instr_q == c_intest);
    dr_so  = is_bsr ? bsr_so : (is_id ? id_so : byp_q);

    tdo_en        = (st == TAP_SH_DR) || (st == TAP_SH_IR);
    tdo           = 1'b0;
    if (st == TAP_SH_IR)      tdo = ir_sr_q[0];
    else if (st == TAP_SH_DR) tdo = dr_so;

    bc_capture_en = !(is_bsr && ((st == TAP_CAP_DR) || (st == TAP_SH_DR)));
    bc_shift_dr   = is_bsr && (st == TAP_SH_DR);
    bc_update_en  = is_bsr && (st == TAP_UPD_DR);
    bc_mode       = (instr_q == c_extest) || (instr_q == c_intest);
    bc_intest     = (instr_q == c_intest);
    bc_si         = tdi;
    tap_state     = state;
    instr         = instr_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_bscan_tap_ctrl.sv
// ============================================================================
// tb_bscan_tap_ctrl : randomized bench for bscan_tap_ctrl against a TAP model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bscan_tap_ctrl;

  localparam int          IR_W   = 4;
  localparam logic [31:0] ID_VAL = 32'hABCD_1234;
`ifdef BSCAN_TAP_IDCODE_EN
  localparam logic [3:0]  RST_INSTR = 4'h3;
`else
  localparam logic [3:0]  RST_INSTR = 4'hF;
`endif

  localparam int S_EX2DR = 0,  S_EX1DR = 1,  S_SHDR = 2,   S_PADR = 3;
  localparam int S_SELIR = 4,  S_UPDDR = 5,  S_CAPDR = 6,  S_SELDR = 7;
  localparam int S_EX2IR = 8,  S_EX1IR = 9,  S_SHIR = 10,  S_PAIR = 11;
  localparam int S_RTI   = 12, S_UPDIR = 13, S_CAPIR = 14, S_TLR = 15;

  logic clk, rst_n, tms, tdi, bsr_so;
  logic tdo, tdo_en, bc_capture_en, bc_update_en, bc_shift_dr, bc_mode, bc_intest, bc_si;
  logic [3:0]      tap_state;
  logic [IR_W-1:0] instr;

  bscan_tap_ctrl #(
    .IR_W       (IR_W),
    .IDCODE_VAL (ID_VAL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tms           (tms),
    .tdi           (tdi),
    .bsr_so        (bsr_so),
    .tdo           (tdo),
    .tdo_en        (tdo_en),
    .bc_capture_en (bc_capture_en),
    .bc_update_en  (bc_update_en),
    .bc_shift_dr   (bc_shift_dr),
    .bc_mode       (bc_mode),
    .bc_intest     (bc_intest),
    .bc_si         (bc_si),
    .tap_state     (tap_state),
    .instr         (instr)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  int   nxt [16][2];
  int   m_state;
  logic [3:0]  m_instr, m_ir;
  logic        m_byp;
  logic [31:0] m_id;
  int   cnt_cap, cnt_sh, cnt_upd;
  logic tdo_q [$];
  bit   chk_on = 0;
  bit   e_bsr, e_id, e_tdo;
  logic [31:0] got, rnd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_TLR;
    m_instr = RST_INSTR;
    m_ir    = 4'h0;
    m_byp   = 1'b0;
    m_id    = ID_VAL | 32'h1;
  endtask

  task automatic model_update();
    int ns;
    if (!rst_n) return;
    ns = nxt[m_state][tms];
    if (m_state == S_CAPIR) m_ir = 4'h1;
    if (m_state == S_SHIR)  m_ir = (m_ir >> 1) | (4'(tdi) << 3);
    if (m_state == S_CAPDR) begin m_byp = 1'b0; m_id = ID_VAL | 32'h1; end
    if (m_state == S_SHDR)  begin m_byp = tdi;  m_id = (m_id >> 1) | (32'(tdi) << 31); end
    if (m_state == S_UPDIR) m_instr = m_ir;
    if (ns == S_TLR)        m_instr = RST_INSTR;
    m_state = ns;
  endtask

  // one TCK: drive, observe at the falling edge, advance the model at the rising edge
  task automatic step(input logic t, input logic d, input bit rec);
    tms = t; tdi = d; bsr_so = 1'($urandom);
    @(negedge clk);
    if (rec) tdo_q.push_back(tdo);
    if (!bc_capture_en) cnt_cap++;
    if (bc_shift_dr)    cnt_sh++;
    if (bc_update_en)   cnt_upd++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    tdo_q.delete(); cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
  endtask

  task automatic pack_tdo();
    got = '0;
    foreach (tdo_q[i]) got[i] = tdo_q[i];
  endtask

  task automatic ir_scan(input logic [3:0] v);
    clr();
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < IR_W; i++) step(i == IR_W-1, v[i], 1);
    step(1, 0, 0); step(0, 0, 0);
    pack_tdo();
  endtask

  task automatic dr_scan(input int n, input logic [31:0] bits);
    clr();
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < n; i++) step(i == n-1, bits[i], 1);
    step(1, 0, 0); step(0, 0, 0);
    pack_tdo();
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      e_bsr = (m_instr < 4'd3);
`ifdef BSCAN_TAP_IDCODE_EN
      e_id  = (m_instr == 4'd3);
`else
      e_id  = 1'b0;
`endif
      e_tdo = 1'b0;
      if (m_state == S_SHIR) e_tdo = m_ir[0];
      if (m_state == S_SHDR) e_tdo = e_bsr ? bsr_so : (e_id ? m_id[0] : m_byp);
      check("tap_state", tap_state, m_state);
      check("instr", instr, m_instr);
      check("tdo_en", tdo_en, (m_state == S_SHDR) || (m_state == S_SHIR));
      check("tdo", tdo, e_tdo);
      check("bc_capture_en", bc_capture_en, !(e_bsr && (m_state == S_CAPDR || m_state == S_SHDR)));
      check("bc_shift_dr", bc_shift_dr, e_bsr && m_state == S_SHDR);
      check("bc_update_en", bc_update_en, e_bsr && m_state == S_UPDDR);
      check("bc_mode", bc_mode, m_instr == 4'd0 || m_instr == 4'd2);
      check("bc_intest", bc_intest, m_instr == 4'd2);
      check("bc_si", bc_si, tdi);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nxt[S_TLR]   = '{S_RTI,   S_TLR};
    nxt[S_RTI]   = '{S_RTI,   S_SELDR};
    nxt[S_SELDR] = '{S_CAPDR, S_SELIR};
    nxt[S_CAPDR] = '{S_SHDR,  S_EX1DR};
    nxt[S_SHDR]  = '{S_SHDR,  S_EX1DR};
    nxt[S_EX1DR] = '{S_PADR,  S_UPDDR};
    nxt[S_PADR]  = '{S_PADR,  S_EX2DR};
    nxt[S_EX2DR] = '{S_SHDR,  S_UPDDR};
    nxt[S_UPDDR] = '{S_RTI,   S_SELDR};
    nxt[S_SELIR] = '{S_CAPIR, S_TLR};
    nxt[S_CAPIR] = '{S_SHIR,  S_EX1IR};
    nxt[S_SHIR]  = '{S_SHIR,  S_EX1IR};
    nxt[S_EX1IR] = '{S_PAIR,  S_UPDIR};
    nxt[S_PAIR]  = '{S_PAIR,  S_EX2IR};
    nxt[S_EX2IR] = '{S_SHIR,  S_UPDIR};
    nxt[S_UPDIR] = '{S_RTI,   S_SELDR};

    clk = 0; rst_n = 0; tms = 1; tdi = 0; bsr_so = 0;
    model_reset();
    @(posedge clk); #1;
    chk_on = 1;
    check("reset tap_state", tap_state, 4'hF);
    check("reset instr", instr, RST_INSTR);
    check("reset capture_en", bc_capture_en, 1'b1);
    check("reset tdo_en", tdo_en, 1'b0);
    check("reset bc_mode", bc_mode, 1'b0);
    step(1, 0, 0); step(1, 0, 0);
    rst_n = 1;

    // first DR scan after reset: IDCODE when present, otherwise BYPASS
    step(0, 0, 0);
    rnd = $urandom;
    dr_scan(32, rnd);
`ifdef BSCAN_TAP_IDCODE_EN
    check("boot idcode", got, 32'hABCD_1235);
`else
    check("boot bypass", got, rnd << 1);
`endif

    ir_scan(4'h0);
    check("ir capture 1000", got[3:0], 4'b0001);
    check("extest instr", instr, 4'h0);
    check("extest bc_mode", bc_mode, 1'b1);

    dr_scan(8, $urandom);
    check("extest capture_en low", cnt_cap, 9);
    check("extest shift_dr high", cnt_sh, 8);
    check("extest update pulses", cnt_upd, 1);

    ir_scan(4'hF);
    dr_scan(4, 32'b1101);
    check("bypass tdo 0101", got[3:0], 4'b1010);
    check("bypass capture_en low", cnt_cap, 0);
    check("bypass update pulses", cnt_upd, 0);

    ir_scan(4'h1);
    check("sample bc_mode", bc_mode, 1'b0);

    ir_scan(4'h3);
    rnd = $urandom;
    dr_scan(32, rnd);
`ifdef BSCAN_TAP_IDCODE_EN
    check("idcode scan", got, 32'hABCD_1235);
`else
    check("idcode as bypass", got, rnd << 1);
`endif

    // reset in the middle of an INTEST shift
    ir_scan(4'h2);
    check("intest bc_intest", bc_intest, 1'b1);
    clr();
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
    rst_n = 0;
    model_reset();
    #1;
    check("midshift rst tap_state", tap_state, 4'hF);
    check("midshift rst bc_intest", bc_intest, 1'b0);
    check("midshift rst tdo_en", tdo_en, 1'b0);
    step(1, 0, 0); step(0, 0, 0);
    rst_n = 1;
    step(0, 0, 0); step(0, 0, 0);
    check("midshift no update", cnt_upd, 0);

    // five tms=1 from wherever a random walk left the TAP
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < int'($urandom_range(3, 25)); i++) step(1'($urandom), 1'($urandom), 0);
      for (int i = 0; i < 5; i++) step(1, 1'($urandom), 0);
      check("tms5 tap_state", tap_state, 4'hF);
      check("tms5 instr", instr, RST_INSTR);
    end

    for (int i = 0; i < 3000; i++) step(1'($urandom), 1'($urandom), 0);

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
